// File: rtl/fifo_pkg.sv
// Shared types for the team fifo and its read-side helpers.
// The buffer state encoding matches the fifo EMPTY/PAR/FULL encoding.
package fifo_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    function automatic int unsigned beat_width(input int unsigned burst);
        return (burst > 1) ? $clog2(burst) : 1;
    endfunction

    function automatic logic [1:0] occupancy(input buf_state_t s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            BUF_ONE: n = 2'd1;
            BUF_TWO: n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry output buffer: head slot drives the stream, tail slot absorbs
// the word still returning from the fifo while the consumer stalls.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int unsigned M = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [M-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [M-1:0] head,
    output logic [1:0]   occ
);

    buf_state_t   state;
    logic [M-1:0] tail;

    assign valid = (state != BUF_EMPTY);
    assign occ   = occupancy(state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BUF_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            state <= BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (push) begin
                        head  <= push_data;
                        state <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail  <= push_data;
                            state <= BUF_TWO;
                        end
                        2'b01: state <= BUF_EMPTY;
                        2'b11: head  <= push_data;
                        default: ;
                    endcase
                end
                BUF_TWO: begin
                    if (pop) begin
                        head <= tail;
                        if (push) begin
                            tail <= push_data;
                        end else begin
                            state <= BUF_ONE;
                        end
                    end
                end
                default: state <= BUF_EMPTY;
            endcase
        end
    end

    // The upstream credit check must never let a word land on a full buffer.
    assert property (@(posedge clk) disable iff (rst || flush) !(push && !pop && state == BUF_TWO))
        else $error("skid_buf2: push into full buffer");

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the team fifo read port onto a valid/ready stream, hiding the fifo
// one-cycle read latency and tagging the last word of every BURST.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned M     = 10,
    parameter int unsigned BURST = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic [M-1:0]     fifo_dout,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [M-1:0]     m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] words_sent
);

    localparam int unsigned           BEAT_W    = beat_width(BURST);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST - 1);

    logic              inflight;
    logic              pop;
    logic [1:0]        occ;
    logic [1:0]        load;
    logic [BEAT_W-1:0] beat_cnt;

    assign pop  = m_valid && m_ready;
    assign load = occ + {1'b0, inflight};

    // A word leaving this cycle frees its slot in time for a read issued now,
    // which is what keeps fifo_rd continuously high at full throughput.
    assign fifo_rd = !rst && !flush && !fifo_empty &&
                     ((load < 2'd2) || ((load == 2'd2) && pop));

    assign m_last = m_valid && (beat_cnt == LAST_BEAT);

    skid_buf2 #(
        .M(M)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (inflight),
        .push_data (fifo_dout),
        .pop       (pop),
        .valid     (m_valid),
        .head      (m_data),
        .occ       (occ)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight   <= 1'b0;
            beat_cnt   <= '0;
            words_sent <= '0;
        end else begin
            inflight <= fifo_rd;
            if (pop) begin
                words_sent <= words_sent + CNT_W'(1);
            end
            if (flush) begin
                beat_cnt <= '0;
            end else if (pop) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: emulated fifo, queue-based stream model and
// directed scenarios with hand-computed expectations.
module tb_fifo_stream_reader;

    localparam int M     = 10;
    localparam int BURST = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         m_ready = 1'b0;
    logic         fifo_empty;
    logic [M-1:0] fifo_dout = '0;

    logic         fifo_rd, m_valid, m_last;
    logic [M-1:0] m_data;
    logic [15:0]  words_sent;
    logic         fifo_rd4, m_valid4, m_last4;
    logic [M-1:0] m_data4;
    logic [3:0]   words_sent4;

    fifo_stream_reader #(.M(M), .BURST(BURST), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .fifo_dout(fifo_dout), .flush(flush), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .words_sent(words_sent)
    );

    fifo_stream_reader #(.M(M), .BURST(BURST), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd4),
        .fifo_dout(fifo_dout), .flush(flush), .m_valid(m_valid4),
        .m_ready(m_ready), .m_data(m_data4), .m_last(m_last4),
        .words_sent(words_sent4)
    );

    always #5 clk = ~clk;

    // emulated fifo: registered read data one cycle after fifo_rd
    logic [M-1:0] fifo_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd) begin
            rd_cnt <= rd_cnt + 1;
            if (rd_ptr != wr_ptr) begin
                fifo_dout <= fifo_mem[rd_ptr % 256];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // stream model: every word fetched becomes visible two cycles after its read
    typedef struct {
        logic [M-1:0] w;
        int           arr;
    } ent_t;

    ent_t         q[$];
    logic [M-1:0] log_data[$];
    logic         log_last[$];
    int           mrd = 0;
    int           tot = 0;
    int           beat = 0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                q.delete();
                tot  = 0;
                beat = 0;
                chk("rst_valid", m_valid, 0);
                chk("rst_last", m_last, 0);
                chk("rst_rd", fifo_rd, 0);
                chk("rst_ws", words_sent, 0);
                chk("rst_ws4", words_sent4, 0);
            end else begin
                logic ev, el, erd, epop;
                ev   = (q.size() > 0) && (q[0].arr <= cyc);
                epop = ev && m_ready;
                el   = ev && (beat == BURST - 1);
                erd  = !flush && !fifo_empty && ((int'(q.size()) - (epop ? 1 : 0)) < 2);
                chk("valid", m_valid, ev);
                chk("last", m_last, el);
                chk("rd", fifo_rd, erd);
                chk("ws", words_sent, tot % 65536);
                chk("valid4", m_valid4, ev);
                chk("rd4", fifo_rd4, erd);
                chk("ws4", words_sent4, tot % 16);
                if (ev) begin
                    chk("data", m_data, q[0].w);
                    chk("data4", m_data4, q[0].w);
                end
                if (epop) begin
                    log_data.push_back(m_data);
                    log_last.push_back(m_last);
                    void'(q.pop_front());
                    tot++;
                    beat = (beat + 1) % BURST;
                end
                if (flush) begin
                    q.delete();
                    beat = 0;
                end
                if (erd) begin
                    q.push_back('{w: fifo_mem[mrd % 256], arr: cyc + 2});
                    mrd++;
                end
            end
            cyc++;
        end
    end

    task automatic push_words(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr % 256] = M'(base + i);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic chk_log(input string name, input int l0, input int base,
                           input int n, input logic [15:0] mask);
        chk({name, "_count"}, log_data.size() - l0, n);
        if (log_data.size() - l0 >= n) begin
            for (int i = 0; i < n; i++) begin
                chk({name, "_data"}, log_data[l0 + i], base + i);
                chk({name, "_last"}, log_last[l0 + i], mask[i]);
            end
        end
    endtask

    int r0, l0;

    initial begin
        push_words(1, 5);
        repeat (3) @(negedge clk);
        #3;
        chk("rst_m_data", m_data, 0);
        chk("rst_words_sent", words_sent, 0);

        // 1: pre-loaded 1..5, consumer always ready
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        r0 = rd_cnt;
        l0 = log_data.size();
        repeat (10) @(negedge clk);
        #3;
        chk("t1_ws", words_sent, 5);
        chk("t1_rd_pulses", rd_cnt - r0, 5);
        chk_log("t1", l0, 1, 5, 16'h0008);

        // 2: backpressure with a deep fifo
        @(negedge clk);
        m_ready = 1'b0;
        r0 = rd_cnt;
        push_words(100, 10);
        repeat (6) @(negedge clk);
        #3;
        chk("t2_rd_pulses", rd_cnt - r0, 2);
        chk("t2_valid", m_valid, 1);
        chk("t2_head", m_data, 100);
        @(negedge clk);
        m_ready = 1'b1;
        l0 = log_data.size();
        repeat (15) @(negedge clk);
        #3;
        chk_log("t2", l0, 100, 10, 16'h0044);

        // realign the burst counter before the framing test
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;

        // 3: ready toggling every cycle
        l0 = log_data.size();
        push_words(0, 12);
        for (int i = 0; i < 40; i++) begin
            m_ready = (i % 2 == 0);
            @(negedge clk);
        end
        #3;
        chk_log("t3", l0, 0, 12, 16'h0888);

        // 4: flush while one word buffered and one returning
        @(negedge clk);
        m_ready = 1'b0;
        push_words(200, 1);
        repeat (3) @(negedge clk);
        push_words(201, 1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #3;
        chk("t4_valid_after_flush", m_valid, 0);
        chk("t4_ws_kept", words_sent, 27);
        @(negedge clk);
        l0 = log_data.size();
        push_words(210, 4);
        m_ready = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        chk_log("t4", l0, 210, 4, 16'h0008);

        // 5: fifo runs dry right after a read, then refills
        @(negedge clk);
        r0 = rd_cnt;
        l0 = log_data.size();
        push_words(220, 1);
        repeat (6) @(negedge clk);
        #3;
        chk("t5_rd_pulses", rd_cnt - r0, 1);
        chk_log("t5", l0, 220, 1, 16'h0000);
        @(negedge clk);
        m_ready = 1'b0;
        push_words(221, 1);
        @(negedge clk);
        #3;
        chk("t5_not_yet", m_valid, 0);
        @(negedge clk);
        #3;
        chk("t5_latency_valid", m_valid, 1);
        chk("t5_latency_data", m_data, 221);
        @(negedge clk);
        m_ready = 1'b1;
        repeat (3) @(negedge clk);

        // 6: reset with a buffered word and one in flight
        m_ready = 1'b0;
        push_words(300, 2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_valid", m_valid, 0);
        chk("t6_rd", fifo_rd, 0);
        chk("t6_ws", words_sent, 0);
        chk("t6_ws4", words_sent4, 0);
        @(negedge clk);
        rst = 1'b0;
        push_words(400, 17);
        m_ready = 1'b1;
        repeat (25) @(negedge clk);
        #3;
        chk("t6_ws4_wrap", words_sent4, 1);
        chk("t6_ws_17", words_sent, 17);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
